// File: rtl/uart_rx_core.sv
// UART receiver: synchronised rx line -> one-entry valid/ready holding register.
// Word appears (div>>1)+(nb+parity+1)*div+1 cycles after the start edge; a full, unaccepted register drops new frames (overrun pulse).
module uart_rx_core #(
   parameter int DATA_W      = 9,
   parameter int BAUD_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_i,
   input  logic [BAUD_W-1:0] baud_div_i,
   input  logic [3:0]        data_bits_i,
   input  logic              parity_en_i,
   input  logic              odd_parity_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              parity_error_o,
   output logic              data_bits_error_o,
   output logic              stop_error_o,
   output logic              overrun_o,
   output logic              busy_o
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [3:0] MAX_NB = 4'(DATA_W);

   state_t              state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, fill_q;
   logic                rxs, rxs_prev_q;
   logic [BAUD_W-1:0]   cnt_q, div_q, div_live, half_m1;
   logic [3:0]          nb_q, bit_cnt_q;
   logic                par_en_q, odd_q, dbe_q, perr_q, serr_q, done_q;
   logic [DATA_W-1:0]   shift_q;
   logic                nb_legal;
   logic                cnt_clr, start_ok, data_smp, par_smp, stop_smp;

   logic [DATA_W-1:0]   hold_data_q;
   logic                hold_vld_q, hold_pe_q, hold_dbe_q, hold_se_q, overrun_q;

   assign rxs      = sync_q[SYNC_STAGES-1];
   assign div_live = (baud_div_i < BAUD_W'(4)) ? BAUD_W'(4) : baud_div_i;
   assign half_m1  = (div_live >> 1) - BAUD_W'(1);
   assign nb_legal = (data_bits_i >= 4'd5) && (data_bits_i <= MAX_NB);

   // fill_q marks when the synchroniser holds real line samples, so a line
   // that is low out of reset never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '1;
         fill_q     <= '0;
         rxs_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
         fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         rxs_prev_q <= fill_q[SYNC_STAGES-1] & rxs;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_clr  = 1'b0;
      start_ok = 1'b0;
      data_smp = 1'b0;
      par_smp  = 1'b0;
      stop_smp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rxs_prev_q && !rxs) begin
               state_d = S_START;
               cnt_clr = 1'b1;
            end
         end
         S_START: begin
            if (cnt_q == half_m1) begin
               cnt_clr = 1'b1;
               if (rxs) begin
                  state_d = S_IDLE;
               end else begin
                  start_ok = 1'b1;
                  state_d  = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (cnt_q == div_q - BAUD_W'(1)) begin
               cnt_clr  = 1'b1;
               data_smp = 1'b1;
               if (bit_cnt_q == nb_q - 4'd1)
                  state_d = par_en_q ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (cnt_q == div_q - BAUD_W'(1)) begin
               cnt_clr = 1'b1;
               par_smp = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == div_q - BAUD_W'(1)) begin
               cnt_clr  = 1'b1;
               stop_smp = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         div_q       <= BAUD_W'(4);
         nb_q        <= 4'd8;
         bit_cnt_q   <= '0;
         par_en_q    <= 1'b0;
         odd_q       <= 1'b0;
         dbe_q       <= 1'b0;
         perr_q      <= 1'b0;
         serr_q      <= 1'b0;
         done_q      <= 1'b0;
         shift_q     <= '0;
         hold_data_q <= '0;
         hold_vld_q  <= 1'b0;
         hold_pe_q   <= 1'b0;
         hold_dbe_q  <= 1'b0;
         hold_se_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (cnt_clr || state_q == S_IDLE) cnt_q <= '0;
         else                             cnt_q <= cnt_q + BAUD_W'(1);

         // Frame configuration is frozen here for the rest of the frame.
         if (start_ok) begin
            div_q     <= div_live;
            nb_q      <= nb_legal ? data_bits_i : 4'd8;
            dbe_q     <= !nb_legal;
            par_en_q  <= parity_en_i;
            odd_q     <= odd_parity_i;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            perr_q    <= 1'b0;
         end
         if (data_smp) begin
            shift_q   <= shift_q | (DATA_W'(rxs) << bit_cnt_q);
            bit_cnt_q <= bit_cnt_q + 4'd1;
         end
         if (par_smp)  perr_q <= ((^shift_q) ^ rxs) != odd_q;
         if (stop_smp) serr_q <= ~rxs;
         done_q <= stop_smp;

         overrun_q <= 1'b0;
         if (done_q) begin
            if (!hold_vld_q || rx_ready_i) begin
               hold_data_q <= shift_q;
               hold_vld_q  <= 1'b1;
               hold_pe_q   <= perr_q;
               hold_dbe_q  <= dbe_q;
               hold_se_q   <= serr_q;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (hold_vld_q && rx_ready_i) begin
            hold_data_q <= '0;
            hold_vld_q  <= 1'b0;
            hold_pe_q   <= 1'b0;
            hold_dbe_q  <= 1'b0;
            hold_se_q   <= 1'b0;
         end
      end
   end

   assign rx_data_o         = hold_data_q;
   assign rx_valid_o        = hold_vld_q;
   assign parity_error_o    = hold_pe_q;
   assign data_bits_error_o = hold_dbe_q;
   assign stop_error_o      = hold_se_q;
   assign overrun_o         = overrun_q;
   assign busy_o            = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive engine that turns the serial input line into parallel data words for the receive FIFO and CSR block. It uses the run-time configuration held in the baud-rate and control_0 CSRs: clocks per bit, data bits, parity enable and parity polarity. It drives the receive-side status fields (busy, data_valid, parity_error, data_bits_error). Received words are offered through a one-entry valid/ready holding register, with overrun detection.

Parameters:
DATA_W, 9, maximum supported data bits and width of rx_data
BAUD_W, 32, width of the baud divisor (matches the CSR data width)
SYNC_STAGES, 2, number of flops in the rx input synchroniser (minimum 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_i  in  1  asynchronous serial line; idles high
baud_div_i  in  BAUD_W  clocks per bit (CSR reset value 5208)
data_bits_i  in  4  data bits per frame
parity_en_i  in  1  1 = parity bit present
odd_parity_i  in  1  1 = odd parity, 0 = even parity
rx_data_o  out  DATA_W  received word, LSB = first bit on the line, unused MSBs = 0
rx_valid_o  out  1  holding register full
rx_ready_i  in  1  consumer accepts the word when rx_valid_o && rx_ready_i
parity_error_o  out  1  parity error for the word in the holding register
data_bits_error_o  out  1  illegal data_bits for the word in the holding register
stop_error_o  out  1  stop bit sampled low for the word in the holding register
overrun_o  out  1  one-cycle pulse: a completed frame was dropped
busy_o  out  1  receiver is inside a frame

Behaviour:
- Reset: state = IDLE; all synchroniser flops = 1; holding register cleared; rx_data_o = 0; all error outputs, rx_valid_o, overrun_o and busy_o = 0.
- The FSM uses the synchronised line (rxs) only.
- Effective divisor: div = max(baud_div_i, 4). Cycle counter cnt is cleared on every state entry and on every sample.
- IDLE: a falling edge of rxs (previous 1, current 0) moves to START. A line that is already low at reset is not a start; a high level must be seen first.
- START: when cnt == (div>>1)-1, sample rxs.
  - rxs = 1: false start, return to IDLE.
  - rxs = 0: latch div, the data bit count nb and the parity settings, then go to DATA.
  - nb = data_bits_i if 5 <= data_bits_i <= DATA_W. Otherwise nb = 8 and the frame's data_bits_error = 1.
  - CSR changes after this latch do not affect the current frame.
- DATA: sample every div cycles (cnt == div-1) and shift LSB-first. After nb samples go to PARITY if parity is enabled, else to STOP.
- PARITY: one sample. Error when (XOR of the data bits) XOR (parity bit) != odd_parity.
- STOP: one sample; stop_error = ~rxs. Return to IDLE in the same cycle, so a start edge on the very next cycle is detected.
- busy_o = 1 in START, DATA, PARITY and STOP.
- Completion: in the cycle after the STOP sample, the frame (data plus the three error flags) is written into the holding register and rx_valid_o rises.
  - Latency from the rxs falling edge to rx_valid_o is (div>>1) + (nb + parity + 1)*div + 1 cycles.
- Handshake: rx_valid_o stays high and rx_data_o / error outputs stay stable until rx_valid_o && rx_ready_i. They clear on the next cycle unless a new frame loads in that same cycle.
- Completion while the holding register is full and rx_ready_i = 0: the new frame is dropped, the held word is kept, and overrun_o pulses for 1 cycle.
- Completion in the same cycle as acceptance (rx_ready_i = 1): the new frame loads, rx_valid_o stays 1, and there is no overrun.
- rst asserted mid-frame: the frame is abandoned and everything returns to reset values on the next edge.

Test Plan:
- baud_div = 16, 8 bits, odd parity, send 0xA5 with parity bit 1, rx_ready held 1 -> rx_data = 0x0A5, no errors; rx_valid high 8+9*16+16+1 = 169 cycles after the start edge.
- Same settings but parity bit 0 -> rx_data = 0x0A5, parity_error = 1. Even parity with parity bit 0 -> no error.
- data_bits = 5, no parity, send 0x13 followed by a low stop bit -> rx_data = 0x13, stop_error = 1. Then data_bits = 3 -> frame received as 8 bits with data_bits_error = 1.
- Glitch: rx low for 4 cycles at baud_div = 16 -> false start; FSM back in IDLE, busy drops, no rx_valid.
- rx_ready = 0, send 0x11 then 0x22 back-to-back -> 0x11 is held, overrun pulses once when 0x22 completes. Then rx_ready = 1 in the completion cycle of a third frame 0x33 -> 0x33 loads with no overrun.
- Assert rst for 1 cycle during DATA, then send 0x5A -> the partial frame is discarded and rx_data = 0x5A is received cleanly.
